// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer stream packer.
// Data path sizes here must agree with the IW/R parameters of la_str_pack.
package la_pkg;

   localparam int LA_IW = 16;
   localparam int LA_R  = 4;
   localparam int OW    = LA_IW * LA_R;
   localparam int KW    = OW / 8;
   localparam int BKW   = LA_IW / 8;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_e;

   // Replace lane k of a wide data word with one input beat.
   function automatic logic [OW-1:0] put_beat(input logic [OW-1:0] word,
                                              input logic [LA_IW-1:0] beat,
                                              input int unsigned k);
      logic [OW-1:0] res;
      res = word;
      res[k*LA_IW +: LA_IW] = beat;
      return res;
   endfunction

   // Same placement for the byte-enable vector.
   function automatic logic [KW-1:0] put_keep(input logic [KW-1:0] word,
                                              input logic [BKW-1:0] keep,
                                              input int unsigned k);
      logic [KW-1:0] res;
      res = word;
      res[k*BKW +: BKW] = keep;
      return res;
   endfunction

endpackage

// File: rtl/la_str_pack_tmo.sv
// Idle flush timer for a partially filled packer word.
// Counts idle cycles while a partial word waits; fires when the count
// equals cfg_tmo (cfg_tmo==0 never fires). Clears after firing.
module la_str_pack_tmo #(
   parameter int TCW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ctl_rst,
   input  logic           clr,
   input  logic           inc,
   input  logic [TCW-1:0] cfg_tmo,
   output logic           fire
);

   logic [TCW-1:0] cnt_q, cnt_d;

   assign fire = (cfg_tmo != '0) && (cnt_q == cfg_tmo);

   // Next count: clear on activity or expiry, otherwise saturating increment.
   always_comb begin
      cnt_d = cnt_q;
      if (ctl_rst || clr || fire) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + TCW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/la_str_pack.sv
// Packs R narrow RLE beats into one wide word for the memory-side writer.
// Partial words close on TLAST. Optional idle flush timer under
// LA_PACK_TMO_EN (adds cfg_tmo port).
//
// state | meaning
// FILL  | accumulator accepting beats
// HOLD  | accumulator complete, waiting for the output register to free up
module la_str_pack
   import la_pkg::*;
#(
   parameter int IW = LA_IW,
   parameter int R  = LA_R,
   parameter int CW = 32
`ifdef LA_PACK_TMO_EN
   ,parameter int TCW = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ctl_rst,
   input  logic [IW-1:0]     sti_tdata,
   input  logic [IW/8-1:0]   sti_tkeep,
   input  logic              sti_tlast,
   input  logic              sti_tvalid,
   output logic              sti_tready,
   output logic [IW*R-1:0]   sto_tdata,
   output logic [IW*R/8-1:0] sto_tkeep,
   output logic              sto_tlast,
   output logic              sto_tvalid,
   input  logic              sto_tready,
`ifdef LA_PACK_TMO_EN
   input  logic [TCW-1:0]    cfg_tmo,
`endif
   output logic [CW-1:0]     sts_cnt
);

   localparam int IDXW = (R > 1) ? $clog2(R) : 1;

   pack_state_e      state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [OW-1:0]    acc_dat_q, acc_dat_d;
   logic [KW-1:0]    acc_kep_q, acc_kep_d;
   logic             acc_lst_q, acc_lst_d;
   logic [OW-1:0]    out_dat_q, out_dat_d;
   logic [KW-1:0]    out_kep_q, out_kep_d;
   logic             out_lst_q, out_lst_d;
   logic             out_vld_q, out_vld_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic             out_free;
   logic             last_lane;
   logic             tmo_fire;
   logic             cmp;
   logic [OW-1:0]    mrg_dat, cmp_dat;
   logic [KW-1:0]    mrg_kep, cmp_kep;
   logic             cmp_lst;

   assign sti_tready = (state_q == FILL) && !rst;
   assign accept     = sti_tvalid && sti_tready;
   assign out_free   = !out_vld_q || sto_tready;
   assign last_lane  = (idx_q == IDXW'(R-1));

   assign mrg_dat = put_beat(acc_dat_q, sti_tdata, int'(idx_q));
   assign mrg_kep = put_keep(acc_kep_q, sti_tkeep, int'(idx_q));

`ifdef LA_PACK_TMO_EN
   logic tmo_raw;

   la_str_pack_tmo #(.TCW(TCW)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .ctl_rst (ctl_rst),
      .clr     (accept || (idx_q == '0)),
      .inc     ((state_q == FILL) && (idx_q != '0) && !accept),
      .cfg_tmo (cfg_tmo),
      .fire    (tmo_raw)
   );

   // An expiry only closes a word that is still filling and idle this cycle.
   assign tmo_fire = tmo_raw && (state_q == FILL) && (idx_q != '0) && !accept;
`else
   assign tmo_fire = 1'b0;
`endif

   // A completed word is the merged accumulator on a closing beat, or the
   // bare accumulator on a timeout flush (never carries tlast).
   assign cmp     = (accept && (last_lane || sti_tlast)) || tmo_fire;
   assign cmp_dat = accept ? mrg_dat : acc_dat_q;
   assign cmp_kep = accept ? mrg_kep : acc_kep_q;
   assign cmp_lst = accept && sti_tlast;

   // Next-state for accumulator, output register, FSM and handshake counter.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_dat_d = acc_dat_q;
      acc_kep_d = acc_kep_q;
      acc_lst_d = acc_lst_q;
      out_dat_d = out_dat_q;
      out_kep_d = out_kep_q;
      out_lst_d = out_lst_q;
      out_vld_d = out_vld_q;
      cnt_d     = cnt_q;

      if (out_vld_q && sto_tready) begin
         out_vld_d = 1'b0;
         cnt_d     = cnt_q + CW'(1);
      end

      case (state_q)
         FILL: begin
            if (cmp) begin
               idx_d = '0;
               if (out_free) begin
                  out_dat_d = cmp_dat;
                  out_kep_d = cmp_kep;
                  out_lst_d = cmp_lst;
                  out_vld_d = 1'b1;
                  acc_dat_d = '0;
                  acc_kep_d = '0;
                  acc_lst_d = 1'b0;
               end else begin
                  acc_dat_d = cmp_dat;
                  acc_kep_d = cmp_kep;
                  acc_lst_d = cmp_lst;
                  state_d   = HOLD;
               end
            end else if (accept) begin
               acc_dat_d = mrg_dat;
               acc_kep_d = mrg_kep;
               idx_d     = idx_q + IDXW'(1);
            end
         end
         HOLD: begin
            if (out_free) begin
               out_dat_d = acc_dat_q;
               out_kep_d = acc_kep_q;
               out_lst_d = acc_lst_q;
               out_vld_d = 1'b1;
               acc_dat_d = '0;
               acc_kep_d = '0;
               acc_lst_d = 1'b0;
               state_d   = FILL;
            end
         end
         default: state_d = FILL;
      endcase

      // Soft reset overrides any handshake in the same cycle.
      if (ctl_rst) begin
         state_d   = FILL;
         idx_d     = '0;
         acc_dat_d = '0;
         acc_kep_d = '0;
         acc_lst_d = 1'b0;
         out_dat_d = '0;
         out_kep_d = '0;
         out_lst_d = 1'b0;
         out_vld_d = 1'b0;
         cnt_d     = '0;
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FILL;
         idx_q     <= '0;
         acc_dat_q <= '0;
         acc_kep_q <= '0;
         acc_lst_q <= 1'b0;
         out_dat_q <= '0;
         out_kep_q <= '0;
         out_lst_q <= 1'b0;
         out_vld_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         acc_dat_q <= acc_dat_d;
         acc_kep_q <= acc_kep_d;
         acc_lst_q <= acc_lst_d;
         out_dat_q <= out_dat_d;
         out_kep_q <= out_kep_d;
         out_lst_q <= out_lst_d;
         out_vld_q <= out_vld_d;
         cnt_q     <= cnt_d;
      end
   end

   assign sto_tdata  = out_dat_q;
   assign sto_tkeep  = out_kep_q;
   assign sto_tlast  = out_lst_q;
   assign sto_tvalid = out_vld_q;
   assign sts_cnt    = cnt_q;

endmodule

// File: tb/tb_la_str_pack.sv
// Scoreboard bench for la_str_pack: directed beats push expected words,
// a monitor pops and compares on every output handshake.
module tb_la_str_pack;

   logic        clk = 1'b0;
   logic        rst;
   logic        ctl_rst;
   logic [15:0] sti_tdata;
   logic [1:0]  sti_tkeep;
   logic        sti_tlast;
   logic        sti_tvalid;
   logic        sti_tready;
   logic [63:0] sto_tdata;
   logic [7:0]  sto_tkeep;
   logic        sto_tlast;
   logic        sto_tvalid;
   logic        sto_tready;
   logic [31:0] sts_cnt;
`ifdef LA_PACK_TMO_EN
   logic [15:0] cfg_tmo;
`endif

   typedef struct packed {
      logic        l;
      logic [7:0]  k;
      logic [63:0] d;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_err  = 0;
   int   stalls = 0;

   la_str_pack dut (
      .clk        (clk),
      .rst        (rst),
      .ctl_rst    (ctl_rst),
      .sti_tdata  (sti_tdata),
      .sti_tkeep  (sti_tkeep),
      .sti_tlast  (sti_tlast),
      .sti_tvalid (sti_tvalid),
      .sti_tready (sti_tready),
      .sto_tdata  (sto_tdata),
      .sto_tkeep  (sto_tkeep),
      .sto_tlast  (sto_tlast),
      .sto_tvalid (sto_tvalid),
      .sto_tready (sto_tready),
`ifdef LA_PACK_TMO_EN
      .cfg_tmo    (cfg_tmo),
`endif
      .sts_cnt    (sts_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
      exp_t e;
      e.d = d;
      e.k = k;
      e.l = l;
      exp_q.push_back(e);
   endtask

   // Call at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [15:0] d, input logic [1:0] k, input logic l);
      int g;
      g = 0;
      sti_tdata  = d;
      sti_tkeep  = k;
      sti_tlast  = l;
      sti_tvalid = 1'b1;
      if (!sti_tready) stalls++;
      while (!sti_tready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g >= 50) begin
         n_chk++;
         n_err++;
         $display("FAIL send_timeout: beat %h not accepted within 50 cycles", d);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      sti_tvalid = 1'b0;
      sti_tlast  = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: looks just before each rising edge for an output handshake.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (!rst && !ctl_rst && sto_tvalid && sto_tready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_word: got %h keep %h last %b, expected none",
                        sto_tdata, sto_tkeep, sto_tlast);
            end else begin
               mon_e = exp_q.pop_front();
               chk("word_data", sto_tdata, mon_e.d);
               chk("word_keep", 64'(sto_tkeep), 64'(mon_e.k));
               chk("word_last", 64'(sto_tlast), 64'(mon_e.l));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      ctl_rst    = 1'b0;
      sti_tdata  = '0;
      sti_tkeep  = '0;
      sti_tlast  = 1'b0;
      sti_tvalid = 1'b0;
      sto_tready = 1'b0;
`ifdef LA_PACK_TMO_EN
      cfg_tmo    = '0;
`endif

      // Reset state
      #2;
      chk("rst_tready", 64'(sti_tready), 64'd0);
      chk("rst_tvalid", 64'(sto_tvalid), 64'd0);
      chk("rst_tdata",  sto_tdata, 64'd0);
      chk("rst_tkeep",  64'(sto_tkeep), 64'd0);
      chk("rst_tlast",  64'(sto_tlast), 64'd0);
      chk("rst_cnt",    64'(sts_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_tready", 64'(sti_tready), 64'd1);
      @(negedge clk);

      // Full packing, no backpressure
      sto_tready = 1'b1;
      stalls = 0;
      push(64'h0004_0003_0002_0001, 8'hFF, 1'b0);
      push(64'h0008_0007_0006_0005, 8'hFF, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         send(16'(i), 2'b11, 1'b0);
         if (i == 3) chk("pre_complete_valid", 64'(sto_tvalid), 64'd0);
         if (i == 4) chk("latency_valid", 64'(sto_tvalid), 64'd1);
         if (i == 5) chk("valid_drop", 64'(sto_tvalid), 64'd0);
      end
      idle();
      cycles(3);
      chk("full_no_stall", 64'(stalls), 64'd0);
      chk("full_cnt", 64'(sts_cnt), 64'd2);

      // Early TLAST, then a fresh word from lane 0
      push(64'h0000_0000_BBBB_AAAA, 8'h0F, 1'b1);
      push(64'h0014_0013_0012_0011, 8'hFF, 1'b0);
      send(16'hAAAA, 2'b11, 1'b0);
      send(16'hBBBB, 2'b11, 1'b1);
      for (int i = 0; i < 4; i++) send(16'h0011 + 16'(i), 2'b11, 1'b0);
      idle();
      cycles(3);
      chk("tlast_cnt", 64'(sts_cnt), 64'd4);

      // Backpressure: second word waits in HOLD
      sto_tready = 1'b0;
      push(64'h0024_0023_0022_0021, 8'hFF, 1'b0);
      push(64'h0028_0027_0026_0025, 8'hFF, 1'b0);
      for (int i = 0; i < 8; i++) send(16'h0021 + 16'(i), 2'b11, 1'b0);
      idle();
      chk("hold_tready", 64'(sti_tready), 64'd0);
      chk("hold_valid", 64'(sto_tvalid), 64'd1);
      chk("hold_data", sto_tdata, 64'h0024_0023_0022_0021);
      cycles(3);
      chk("hold_stable", sto_tdata, 64'h0024_0023_0022_0021);
      chk("hold_tready_still", 64'(sti_tready), 64'd0);
      sto_tready = 1'b1;
      cycles(4);
      chk("bp_cnt", 64'(sts_cnt), 64'd6);
      chk("bp_drained", 64'(sto_tvalid), 64'd0);
      chk("bp_tready", 64'(sti_tready), 64'd1);

      // Soft reset drops a held output word and a partial accumulator
      sto_tready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'h0051 + 16'(i), 2'b11, 1'b0);
      send(16'h0031, 2'b11, 1'b0);
      send(16'h0032, 2'b11, 1'b0);
      idle();
      chk("pre_softrst_valid", 64'(sto_tvalid), 64'd1);
      ctl_rst = 1'b1;
      @(negedge clk);
      ctl_rst = 1'b0;
      chk("softrst_valid", 64'(sto_tvalid), 64'd0);
      chk("softrst_cnt", 64'(sts_cnt), 64'd0);
      chk("softrst_data", sto_tdata, 64'd0);
      sto_tready = 1'b1;
      push(64'h0044_0043_0042_0041, 8'hFF, 1'b0);
      for (int i = 0; i < 4; i++) send(16'h0041 + 16'(i), 2'b11, 1'b0);
      idle();
      cycles(3);
      chk("softrst_after_cnt", 64'(sts_cnt), 64'd1);

      // One-lane word with tkeep=0 at lane 0
      push(64'h0000_0000_0000_7777, 8'h00, 1'b1);
      send(16'h7777, 2'b00, 1'b1);
      idle();
      cycles(2);
      chk("onelane_cnt", 64'(sts_cnt), 64'd2);

      // Async reset clears outputs between clock edges
      sto_tready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'h0061 + 16'(i), 2'b11, 1'b0);
      idle();
      chk("arst_pre_valid", 64'(sto_tvalid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", 64'(sto_tvalid), 64'd0);
      chk("arst_data",  sto_tdata, 64'd0);
      chk("arst_keep",  64'(sto_tkeep), 64'd0);
      chk("arst_last",  64'(sto_tlast), 64'd0);
      chk("arst_cnt",   64'(sts_cnt), 64'd0);
      chk("arst_tready", 64'(sti_tready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

`ifdef LA_PACK_TMO_EN
      // Idle flush timeout
      begin
         int n;
         cfg_tmo    = 16'd5;
         sto_tready = 1'b1;
         push(64'h0000_0000_0000_1234, 8'h03, 1'b0);
         send(16'h1234, 2'b11, 1'b0);
         idle();
         n = 0;
         while (!sto_tvalid && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("tmo_latency", 64'(n), 64'd6);
         cycles(3);
      end
`endif

      cycles(2);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
